// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, rotation schedule,
// permutation/rotation helpers and the scheduler state encoding.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } des_state_e;

  // Entries are 1-based DES bit numbers, bit 1 being the MSB of the source.
  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    int          idx;
    res = 56'd0;
    for (int j = 0; j < 56; j++) begin
      idx          = 64 - int'(PC1_TAB[j]);
      res[55 - j]  = k[idx];
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    int          idx;
    res = 48'd0;
    for (int j = 0; j < 48; j++) begin
      idx          = 56 - int'(PC2_TAB[j]);
      res[47 - j]  = cd[idx];
    end
    return res;
  endfunction

  // DES bit 1 is the MSB, so a DES left rotation is a left rotation of the vector.
  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] s);
    logic [27:0] res;
    case (s)
      2'd1:    res = {v[26:0], v[27]};
      2'd2:    res = {v[25:0], v[27:26]};
      default: res = v;
    endcase
    return res;
  endfunction

  // Right rotation used by the decryption-order generator.
  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] s);
    logic [27:0] res;
    case (s)
      2'd1:    res = {v[0], v[27:1]};
      2'd2:    res = {v[1:0], v[27:2]};
      default: res = v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} pair to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  assign subkey = pc2(cd);

endmodule

// File: rtl/des_enc_key_scheduler.sv
// Encryption-order DES subkey streamer (K1..K16, left rotations) with a
// valid/ready output and an optional flat bank of all sixteen subkeys.
module des_enc_key_scheduler
  import des_pkg::*;
#(
  parameter bit BANK_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  key,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic [47:0]  subkey,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic [767:0] skey_bank
);

  des_state_e  state_r, state_nxt_s;
  logic [27:0] c_r, d_r, c_nxt_s, d_nxt_s, c_rot_s, d_rot_s;
  logic [3:0]  rcnt_r, rcnt_nxt_s, round_r, round_nxt_s, shift_idx_s;
  logic [1:0]  shift_amt_s;
  logic [47:0] subkey_r, subkey_nxt_s, pc2_s;
  logic [55:0] pc1_s;
  logic        sk_valid_r, sk_valid_nxt_s, busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic        bank_we_s;

  assign pc1_s = pc1(key);

  // Rotation for the subkey about to be presented: S[0] on RUN entry, S[rcnt+1] on a handshake.
  always_comb begin
    shift_idx_s = 4'd0;
    if (sk_valid_r) begin
      shift_idx_s = rcnt_r + 4'd1;
    end else begin
      shift_idx_s = 4'd0;
    end
    shift_amt_s = SHIFT_TAB[shift_idx_s];
    c_rot_s     = rotl28(c_r, shift_amt_s);
    d_rot_s     = rotl28(d_r, shift_amt_s);
  end

  des_pc2 u_pc2 (
    .cd     ({c_rot_s, d_rot_s}),
    .subkey (pc2_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s    = state_r;
    c_nxt_s        = c_r;
    d_nxt_s        = d_r;
    rcnt_nxt_s     = rcnt_r;
    sk_valid_nxt_s = sk_valid_r;
    subkey_nxt_s   = subkey_r;
    round_nxt_s    = round_r;
    done_nxt_s     = 1'b0;
    bank_we_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          c_nxt_s     = pc1_s[55:28];
          d_nxt_s     = pc1_s[27:0];
          rcnt_nxt_s  = 4'd0;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!sk_valid_r) begin
          c_nxt_s        = c_rot_s;
          d_nxt_s        = d_rot_s;
          subkey_nxt_s   = pc2_s;
          round_nxt_s    = 4'd0;
          sk_valid_nxt_s = 1'b1;
        end else if (sk_ready) begin
          bank_we_s = 1'b1;
          if (rcnt_r == 4'd15) begin
            state_nxt_s    = ST_FIN;
            sk_valid_nxt_s = 1'b0;
            done_nxt_s     = 1'b1;
          end else begin
            c_nxt_s      = c_rot_s;
            d_nxt_s      = d_rot_s;
            subkey_nxt_s = pc2_s;
            rcnt_nxt_s   = rcnt_r + 4'd1;
            round_nxt_s  = rcnt_r + 4'd1;
          end
        end else begin
          sk_valid_nxt_s = sk_valid_r;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, key halves and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      c_r        <= 28'd0;
      d_r        <= 28'd0;
      rcnt_r     <= 4'd0;
      sk_valid_r <= 1'b0;
      subkey_r   <= 48'd0;
      round_r    <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      c_r        <= c_nxt_s;
      d_r        <= d_nxt_s;
      rcnt_r     <= rcnt_nxt_s;
      sk_valid_r <= sk_valid_nxt_s;
      subkey_r   <= subkey_nxt_s;
      round_r    <= round_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign sk_valid = sk_valid_r;
  assign subkey   = subkey_r;
  assign round    = round_r;
  assign busy     = busy_r;
  assign done     = done_r;

  if (BANK_EN) begin : g_bank
    logic [47:0] bank_r [16];

    // Capture each subkey into its slot as it is accepted.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int n = 0; n < 16; n++) begin
          bank_r[n] <= 48'd0;
        end
      end else if (bank_we_s) begin
        bank_r[round_r] <= subkey_r;
      end
    end

    // K1 occupies the most significant 48 bits of the flat bank.
    always_comb begin
      skey_bank = 768'd0;
      for (int n = 0; n < 16; n++) begin
        skey_bank[767 - 48 * n -: 48] = bank_r[n];
      end
    end
  end else begin : g_no_bank
    assign skey_bank = 768'd0;
  end

endmodule

// File: tb/tb_des_enc_key_scheduler.sv
// Directed bench for des_enc_key_scheduler; a BANK_EN=0 copy runs in lockstep.
module tb_des_enc_key_scheduler;

  logic         clk, rst, start, sk_ready;
  logic [63:0]  key;
  logic         sk_valid, busy, done;
  logic [47:0]  subkey;
  logic [3:0]   round;
  logic [767:0] skey_bank;
  logic         sk_valid0, busy0, done0;
  logic [47:0]  subkey0;
  logic [3:0]   round0;
  logic [767:0] skey_bank0;

  int tests = 0;
  int fails = 0;

  logic [47:0] ka [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  logic [47:0] exp_k [16];

  des_enc_key_scheduler #(.BANK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .sk_valid(sk_valid),
    .sk_ready(sk_ready), .subkey(subkey), .round(round), .busy(busy),
    .done(done), .skey_bank(skey_bank)
  );

  des_enc_key_scheduler #(.BANK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key(key), .sk_valid(sk_valid0),
    .sk_ready(sk_ready), .subkey(subkey0), .round(round0), .busy(busy0),
    .done(done0), .skey_bank(skey_bank0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inj_kind: 0 none, 1 start with another key at inj_round, 2 rst at inj_round
  task automatic run_sched(input logic [63:0] k, input bit stall, input int inj_round,
                           input int inj_kind);
    int          got, cyc, first_cyc, stalls;
    bit          aborted, injected;
    logic [767:0] expb;
    expb = 768'd0;
    for (int n = 0; n < 16; n++) expb[767 - 48 * n -: 48] = exp_k[n];
    start = 1'b1; key = k; sk_ready = 1'b1;
    tick();
    start = 1'b0; key = ~k;
    chk("busy_after_start", 768'(busy), 768'(1'b1));
    chk("valid_after_start", 768'(sk_valid), 768'(1'b0));
    got = 0; cyc = 0; first_cyc = -1; stalls = 0; aborted = 1'b0; injected = 1'b0;
    while (got < 16 && cyc < 300 && !aborted) begin
      start = 1'b0;
      sk_ready = stall ? (((cyc * 7 + 3) % 5) < 3) : 1'b1;
      if (sk_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("round", 768'(round), 768'(got));
        chk("subkey", 768'(subkey), 768'(exp_k[got]));
        chk("subkey_nobank", 768'(subkey0), 768'(exp_k[got]));
        chk("valid_nobank", 768'(sk_valid0), 768'(1'b1));
        chk("bank_off_zero", skey_bank0, 768'd0);
        if (inj_kind == 1 && got == inj_round && !injected) begin
          start = 1'b1; key = 64'hFEFEFEFEFEFEFEFE; injected = 1'b1;
        end else if (inj_kind == 2 && got == inj_round) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("rst_valid", 768'(sk_valid), 768'(1'b0));
          chk("rst_busy", 768'(busy), 768'(1'b0));
          chk("rst_round", 768'(round), 768'(4'd0));
          chk("rst_subkey", 768'(subkey), 768'(48'd0));
          chk("rst_bank", skey_bank, 768'd0);
          for (int i = 0; i < 4; i++) begin
            chk("rst_no_done", 768'(done | done0), 768'(1'b0));
            tick();
          end
          aborted = 1'b1;
        end else begin
          injected = injected;
        end
        if (!aborted) begin
          if (sk_ready) got++;
          else stalls++;
        end
      end
      if (!aborted) tick();
      cyc++;
    end
    if (!aborted) begin
      chk("all_accepted", 768'(got), 768'(16));
      if (stall) begin
        chk("stalls_seen", 768'(stalls > 0), 768'(1'b1));
      end else begin
        chk("first_latency", 768'(first_cyc), 768'(1));
        chk("burst_len", 768'(cyc), 768'(17));
      end
      chk("done_pulse", 768'(done), 768'(1'b1));
      chk("done_nobank", 768'(done0), 768'(1'b1));
      chk("valid_fin", 768'(sk_valid), 768'(1'b0));
      chk("busy_fin", 768'(busy), 768'(1'b1));
      chk("bank_k1", 768'(skey_bank[767:720]), 768'(exp_k[0]));
      chk("bank_full", skey_bank, expb);
      start = 1'b1; key = k ^ 64'h0000000000000100;
      tick();
      start = 1'b0;
      chk("done_one_cycle", 768'(done), 768'(1'b0));
      chk("fin_start_ignored", 768'(busy), 768'(1'b0));
      tick();
      chk("idle_after_fin", 768'(busy | sk_valid), 768'(1'b0));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 64'd0; sk_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_valid", 768'(sk_valid), 768'(1'b0));
    chk("reset_busy", 768'(busy), 768'(1'b0));
    chk("reset_done", 768'(done), 768'(1'b0));
    chk("reset_subkey", 768'(subkey), 768'(48'd0));
    chk("reset_round", 768'(round), 768'(4'd0));
    chk("reset_bank", skey_bank, 768'd0);
    rst = 1'b0;
    tick();

    exp_k = ka;
    run_sched(64'h133457799BBCDFF1, 1'b0, 0, 0);
    run_sched(64'h133457799BBCDFF1, 1'b1, 0, 0);

    for (int n = 0; n < 16; n++) exp_k[n] = 48'h000000000000;
    run_sched(64'h0101010101010101, 1'b0, 0, 0);
    for (int n = 0; n < 16; n++) exp_k[n] = 48'hFFFFFFFFFFFF;
    run_sched(64'hFEFEFEFEFEFEFEFE, 1'b1, 0, 0);

    exp_k = ka;
    run_sched(64'h133457799BBCDFF1, 1'b0, 5, 1);
    run_sched(64'h133457799BBCDFF1, 1'b0, 9, 2);
    run_sched(64'h133457799BBCDFF1, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
